// File: rtl/cmdq_pkg.sv
// Shared types and constants for the command queue scheduler.
package cmdq_pkg;
  localparam int CMD_W = 16;
  localparam logic [CMD_W-1:0] ABORT_CMD = 16'hFFFF;
  localparam int FAST_GAP = 8;

  typedef enum logic {I_IDLE, I_WAIT} intake_state_t;
  typedef enum logic [1:0] {O_EMPTY, O_PRESENT, O_GAP} out_state_t;
endpackage

// File: rtl/cmdq_if.sv
// Handshake bundle: UART intake side (in_*) and command processor side (out_*).
interface cmdq_if;
  import cmdq_pkg::*;
  logic [CMD_W-1:0] in_cmd;
  logic             in_rdy;
  logic             in_clr;
  logic [CMD_W-1:0] out_cmd;
  logic             out_rdy;
  logic             out_clr;

  modport slave  (input in_cmd, in_rdy, out_clr, output in_clr, out_cmd, out_rdy);
  modport master (output in_cmd, in_rdy, out_clr, input in_clr, out_cmd, out_rdy);
endinterface

// File: rtl/cmdq_fifo.sv
// Command storage: circular buffer with occupancy count; full/empty derive from the registered count.
module cmdq_fifo
  import cmdq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [CMD_W-1:0]           wdata_i,
  output logic [CMD_W-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/cmd_queue_sched.sv
// Command queue and dispatch scheduler between UART wrapper and command processor.
// Optional CMDQ_ABORT_EN: intake word 16'hFFFF acts as a flush and is never stored.
module cmd_queue_sched
  import cmdq_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int GAP_CYC  = 1024,
  parameter int FAST_SIM = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  cmdq_if.slave                      bus,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovfl
);
  localparam int GAP_LEN = (FAST_SIM != 0) ? FAST_GAP : GAP_CYC;
  localparam int GW      = $clog2(GAP_LEN+1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LEN-1);

  intake_state_t    i_state_q, i_state_d;
  out_state_t       o_state_q, o_state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ovfl_q, ovfl_d;
  logic             full, empty, abort_hit, accept, push, pop, clr_all;
  logic [CMD_W-1:0] head;

`ifdef CMDQ_ABORT_EN
  assign abort_hit = (i_state_q == I_IDLE) && bus.in_rdy && (bus.in_cmd == ABORT_CMD);
`else
  assign abort_hit = 1'b0;
`endif

  // An abort word bypasses the full check; a flushed push is still acknowledged.
  assign accept  = (i_state_q == I_IDLE) && bus.in_rdy && (!full || abort_hit);
  assign clr_all = flush || abort_hit;
  assign push    = accept && !abort_hit && !flush;
  assign pop     = (o_state_q == O_PRESENT) && bus.out_clr && !clr_all;

  assign bus.in_clr  = accept && rst_n;
  assign bus.out_rdy = (o_state_q == O_PRESENT);
  assign bus.out_cmd = empty ? '0 : head;
  assign ovfl        = ovfl_q;

  cmdq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (clr_all),
    .wdata_i (bus.in_cmd),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    i_state_d = i_state_q;
    case (i_state_q)
      I_IDLE:  if (accept) i_state_d = I_WAIT;
      I_WAIT:  if (!bus.in_rdy) i_state_d = I_IDLE;
      default: i_state_d = I_IDLE;
    endcase
  end

  // Gap counter counts down from G-1 so out_rdy returns exactly G edges after the pop.
  always_comb begin
    o_state_d = o_state_q;
    gap_d     = gap_q;
    case (o_state_q)
      O_EMPTY:   if (!empty) o_state_d = O_PRESENT;
      O_PRESENT: if (pop) begin
                   o_state_d = O_GAP;
                   gap_d     = GAP_LOAD;
                 end
      O_GAP:     if (gap_q == '0) o_state_d = empty ? O_EMPTY : O_PRESENT;
                 else gap_d = gap_q - 1'b1;
      default:   o_state_d = O_EMPTY;
    endcase
    if (clr_all) begin
      o_state_d = O_EMPTY;
      gap_d     = '0;
    end
  end

  always_comb begin
    ovfl_d = ovfl_q;
    if (clr_all) ovfl_d = 1'b0;
    else if ((i_state_q == I_IDLE) && bus.in_rdy && full) ovfl_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_state_q <= I_IDLE;
      o_state_q <= O_EMPTY;
      gap_q     <= '0;
      ovfl_q    <= 1'b0;
    end else begin
      i_state_q <= i_state_d;
      o_state_q <= o_state_d;
      gap_q     <= gap_d;
      ovfl_q    <= ovfl_d;
    end
  end
endmodule

// File: tb/tb_cmd_queue_sched.sv
// Directed bench for cmd_queue_sched: vector table plus hand sequences for wrap, abort and reset.
module tb_cmd_queue_sched;
  import cmdq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] count;
  logic       ovfl;

  cmdq_if bus();

  cmd_queue_sched #(.DEPTH(4), .GAP_CYC(1024), .FAST_SIM(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .flush (flush),
    .count (count),
    .ovfl  (ovfl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic        rdy;
    logic        oclr;
    logic        fl;
    logic        e_clr;
    int          e_cnt;
    logic        e_ordy;
    logic [15:0] e_ocmd;
    logic        e_ovfl;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  logic [15:0] w;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] c, input logic r, input logic o, input logic f,
                     input logic ec, input int cnt, input logic ordy,
                     input logic [15:0] ocmd, input logic ov);
    vec_t v;
    v.cmd = c; v.rdy = r; v.oclr = o; v.fl = f;
    v.e_clr = ec; v.e_cnt = cnt; v.e_ordy = ordy; v.e_ocmd = ocmd; v.e_ovfl = ov;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [15:0] c, input logic r, input logic o, input logic f);
    @(negedge clk);
    bus.in_cmd  = c;
    bus.in_rdy  = r;
    bus.out_clr = o;
    flush       = f;
  endtask

  task automatic wait_rdy();
    int t;
    t = 0;
    while (!bus.out_rdy && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("out_rdy wait", bus.out_rdy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    bus.in_cmd  = 16'h0055;
    bus.in_rdy  = 1'b1;
    bus.out_clr = 1'b0;

    // reset held with a word waiting: nothing acknowledged
    @(posedge clk); #1;
    chk("rst in_clr", bus.in_clr, 0);
    chk("rst count", count, 0);
    chk("rst out_rdy", bus.out_rdy, 0);
    chk("rst ovfl", ovfl, 0);
    chk("rst out_cmd", bus.out_cmd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_rdy = 1'b0;

    // single command, then pop and gap with empty queue
    add(16'h0003, 1, 0, 0,  1, 1, 0, 16'h0003, 0);
    add(16'h0003, 0, 0, 0,  0, 1, 1, 16'h0003, 0);
    add(16'h0000, 0, 1, 0,  0, 0, 0, 16'h0000, 0);
    for (int k = 0; k < 9; k++) add(16'h0000, 0, 0, 0,  0, 0, 0, 16'h0000, 0);
    // burst of four
    add(16'h0001, 1, 0, 0,  1, 1, 0, 16'h0001, 0);
    add(16'h0001, 0, 0, 0,  0, 1, 1, 16'h0001, 0);
    add(16'h0002, 1, 0, 0,  1, 2, 1, 16'h0001, 0);
    add(16'h0002, 0, 0, 0,  0, 2, 1, 16'h0001, 0);
    add(16'h0003, 1, 0, 0,  1, 3, 1, 16'h0001, 0);
    add(16'h0003, 0, 0, 0,  0, 3, 1, 16'h0001, 0);
    add(16'h0004, 1, 0, 0,  1, 4, 1, 16'h0001, 0);
    add(16'h0004, 0, 0, 0,  0, 4, 1, 16'h0001, 0);
    // fifth word held while full
    add(16'h0005, 1, 0, 0,  0, 4, 1, 16'h0001, 1);
    add(16'h0005, 1, 0, 0,  0, 4, 1, 16'h0001, 1);
    // pop on edge P0: no same-cycle bypass, then fifth word accepted
    add(16'h0005, 1, 1, 0,  0, 3, 0, 16'h0002, 1);
    add(16'h0005, 1, 0, 0,  1, 4, 0, 16'h0002, 1);
    add(16'h0005, 0, 0, 0,  0, 4, 0, 16'h0002, 1);
    for (int k = 0; k < 5; k++) add(16'h0000, 0, 0, 0,  0, 4, 0, 16'h0002, 1);
    // edge P0+8: second word presented
    add(16'h0000, 0, 0, 0,  0, 4, 1, 16'h0002, 1);
    add(16'h0000, 0, 1, 0,  0, 3, 0, 16'h0003, 1);
    // flush with count=3, ovfl=1 and a simultaneous push
    add(16'h0077, 1, 0, 1,  1, 0, 0, 16'h0000, 0);
    add(16'h0077, 0, 0, 0,  0, 0, 0, 16'h0000, 0);
    add(16'h0000, 0, 0, 0,  0, 0, 0, 16'h0000, 0);
    add(16'h0000, 0, 0, 0,  0, 0, 0, 16'h0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cmd, vecs[i].rdy, vecs[i].oclr, vecs[i].fl);
      #1;
      chk($sformatf("v%0d in_clr", i), bus.in_clr, vecs[i].e_clr);
      @(posedge clk); #1;
      chk($sformatf("v%0d count", i), count, vecs[i].e_cnt);
      chk($sformatf("v%0d out_rdy", i), bus.out_rdy, vecs[i].e_ordy);
      chk($sformatf("v%0d out_cmd", i), bus.out_cmd, vecs[i].e_ocmd);
      chk($sformatf("v%0d ovfl", i), ovfl, vecs[i].e_ovfl);
    end

    // simultaneous push/pop at count=2 across pointer wrap, 12 words total
    for (int k = 0; k < 2; k++) begin
      w = 16'h0100 + 16'(k);
      drive(w, 1, 0, 0); #1;
      chk("prefill in_clr", bus.in_clr, 1);
      exp_q.push_back(w);
      drive(w, 0, 0, 0);
    end
    for (int k = 0; k < 10; k++) begin
      wait_rdy();
      w = 16'h0200 + 16'(k);
      drive(w, 1, 1, 0); #1;
      chk("wrap in_clr", bus.in_clr, 1);
      chk("wrap out_cmd", bus.out_cmd, exp_q.pop_front());
      exp_q.push_back(w);
      @(posedge clk); #1;
      chk("wrap count", count, 2);
      drive(w, 0, 0, 0);
    end
    for (int k = 0; k < 2; k++) begin
      wait_rdy();
      drive(16'h0000, 0, 1, 0); #1;
      chk("drain out_cmd", bus.out_cmd, exp_q.pop_front());
      drive(16'h0000, 0, 0, 0);
    end
    chk("drain count", count, 0);

`ifdef CMDQ_ABORT_EN
    for (int k = 0; k < 4; k++) begin
      drive(16'h0020 + 16'(k), 1, 0, 0);
      drive(16'h0000, 0, 0, 0);
    end
    #1 chk("abort pre count", count, 4);
    drive(16'hFFFF, 1, 0, 0); #1;
    chk("abort in_clr", bus.in_clr, 1);
    @(posedge clk); #1;
    chk("abort count", count, 0);
    chk("abort out_rdy", bus.out_rdy, 0);
    drive(16'hFFFF, 0, 0, 0);
`else
    drive(16'h0010, 1, 0, 0);
    drive(16'h0000, 0, 0, 0);
    #1 chk("ffff pre count", count, 1);
    drive(16'hFFFF, 1, 0, 0); #1;
    chk("ffff in_clr", bus.in_clr, 1);
    @(posedge clk); #1;
    chk("ffff count", count, 2);
    drive(16'hFFFF, 0, 0, 0);
`endif

    // reset mid-operation with a word waiting
    drive(16'h0ABC, 1, 0, 0);
    rst_n = 1'b0;
    #1 chk("midrst in_clr", bus.in_clr, 0);
    @(posedge clk); #1;
    chk("midrst count", count, 0);
    chk("midrst out_rdy", bus.out_rdy, 0);
    chk("midrst out_cmd", bus.out_cmd, 0);
    chk("midrst ovfl", ovfl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
